bf16_addsub_seq: RTL and testbench

- Multi-cycle sequencer for one bfloat16 add/subtract (1 sign, 8 exp, 7 frac).
- Sequences operand capture, exponent alignment, signed mantissa add/sub and iterative normalization.
- Returns the packed result over valid/ready handshakes.
- Sits between the issuing unit and the result writeback in the bf16 arithmetic path; one operation in flight at a time.

---
 rtl/bf16_addsub_seq.sv | 164 ++++++++++++++++
 tb/tb_bf16_addsub_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_addsub_seq.sv
// Multi-cycle bfloat16 add/subtract: capture, align, add, normalize, then hold
// the packed result on a valid/ready handshake. One operation in flight.
module bf16_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int GRD_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 out_zero,
  output logic                 out_ovf
);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1 + GRD_W;
  localparam int SW = MW + 1;
  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W-1:0] EXP_SAT_PRE = EXP_MAX - 1'b1;
  localparam logic [EXP_W-1:0] SHIFT_LIM   = EXP_W'(MW);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_nxt;

  logic [FW-1:0]    op_a;
  logic [FW-2:0]    op_b;
  logic             sign_b_eff;
  logic [EXP_W-1:0] exp_w;
  logic [MW-1:0]    man_a, man_b;
  logic [SW-1:0]    sum;
  logic             sign_r;
  logic             ovf_r;

  logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
  logic [MW-1:0]    ext_a, ext_b;
  logic             a_gt_b;
  logic             norm_zero, norm_right, norm_ready, norm_flush;

  // Zero-exponent operands with a nonzero fraction still get the hidden bit.
  always_comb begin
    exp_a    = op_a[FW-2:MAN_W];
    exp_b    = op_b[FW-2:MAN_W];
    ext_a    = {|op_a[FW-2:0], op_a[MAN_W-1:0], {GRD_W{1'b0}}};
    ext_b    = {|op_b[FW-2:0], op_b[MAN_W-1:0], {GRD_W{1'b0}}};
    a_gt_b   = exp_a > exp_b;
    exp_diff = a_gt_b ? (exp_a - exp_b) : (exp_b - exp_a);
  end

  always_comb begin
    norm_zero  = (sum == '0);
    norm_right = sum[SW-1];
    norm_ready = !sum[SW-1] && sum[SW-2];
    norm_flush = !norm_zero && !sum[SW-1] && !sum[SW-2] && (exp_w == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (norm_zero || norm_ready || norm_flush) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      sign_b_eff <= 1'b0;
      exp_w      <= '0;
      man_a      <= '0;
      man_b      <= '0;
      sum        <= '0;
      sign_r     <= 1'b0;
      ovf_r      <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a       <= a;
            op_b       <= b[FW-2:0];
            sign_b_eff <= b[FW-1] ^ op_sub;
            ovf_r      <= 1'b0;
          end
        end
        ALIGN: begin
          exp_w <= a_gt_b ? exp_a : exp_b;
          if (a_gt_b) begin
            man_a <= ext_a;
            man_b <= (exp_diff >= SHIFT_LIM) ? '0 : (ext_b >> exp_diff);
          end else begin
            man_a <= (exp_diff >= SHIFT_LIM) ? '0 : (ext_a >> exp_diff);
            man_b <= ext_b;
          end
        end
        // Unlike signs subtract the smaller magnitude so the sum stays unsigned.
        ADD: begin
          if (op_a[FW-1] == sign_b_eff) begin
            sum    <= {1'b0, man_a} + {1'b0, man_b};
            sign_r <= op_a[FW-1];
          end else if (man_a > man_b) begin
            sum    <= {1'b0, man_a - man_b};
            sign_r <= op_a[FW-1];
          end else if (man_b > man_a) begin
            sum    <= {1'b0, man_b - man_a};
            sign_r <= sign_b_eff;
          end else begin
            sum    <= '0;
            sign_r <= 1'b0;
          end
        end
        NORM: begin
          if (norm_zero || norm_flush) begin
            result    <= '0;
            out_zero  <= 1'b1;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
          end else if (norm_right) begin
            sum   <= sum >> 1;
            exp_w <= exp_w + 1'b1;
            if (exp_w == EXP_SAT_PRE) ovf_r <= 1'b1;
          end else if (norm_ready) begin
            result    <= ovf_r ? {sign_r, EXP_MAX, {MAN_W{1'b0}}}
                               : {sign_r, exp_w, sum[SW-3 -: MAN_W]};
            out_zero  <= 1'b0;
            out_ovf   <= ovf_r;
            out_valid <= 1'b1;
          end else begin
            sum   <= sum << 1;
            exp_w <= exp_w - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_addsub_seq.sv
// Testbench for bf16_addsub_seq: directed test-plan cases plus randomized operations,
// all checked against a value-level bf16 model with latency and handshake tracking.
module tb_bf16_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, out_zero, out_ovf;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit stall = 1'b0;
  bit bp_en = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    int          hs;
  } exp_t;
  exp_t q[$];

  logic [15:0] dir_a [9] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3FC0, 16'h3F80,
                             16'h7F7F, 16'h0080, 16'h0000, 16'hBF80};
  logic [15:0] dir_b [9] = '{16'h3F00, 16'h3F80, 16'h3F80, 16'h3FA0, 16'h3380,
                             16'h7F7F, 16'h00A0, 16'h8000, 16'h3F00};
  logic        dir_s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  bf16_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Value-level model: signed integer sum of aligned mantissas, then
  // normalization counted as whole shifts.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic sub);
    exp_t r;
    int ea, eb, ma, mb, e, d, s, mag, n;
    logic neg;
    ea = int'(x[14:7]);
    eb = int'(y[14:7]);
    ma = ((x[14:0] != 0) ? 1024 : 0) + int'(x[6:0]) * 8;
    mb = ((y[14:0] != 0) ? 1024 : 0) + int'(y[6:0]) * 8;
    if (ea > eb) begin
      e = ea; d = ea - eb; mb = (d >= 11) ? 0 : (mb >> d);
    end else begin
      e = eb; d = eb - ea; ma = (d >= 11) ? 0 : (ma >> d);
    end
    s = (x[15] ? -ma : ma) + ((y[15] ^ sub) ? -mb : mb);
    neg = (s < 0);
    mag = neg ? -s : s;
    r.res = '0; r.zero = 1'b0; r.ovf = 1'b0; r.lat = 3; r.hs = 0;
    if (mag == 0) begin
      r.zero = 1'b1;
    end else if (mag >= 2048) begin
      e++;
      mag = mag / 2;
      r.lat = 4;
      if (e == 255) begin
        r.ovf = 1'b1;
        r.res = {neg, 8'hFF, 7'h00};
      end else begin
        r.res = {neg, 8'(e), 7'((mag / 8) % 128)};
      end
    end else begin
      n = 0;
      while (mag < 1024 && !r.zero) begin
        if (e == 0) r.zero = 1'b1;
        else begin
          mag = mag * 2; e--; n++;
        end
      end
      r.lat = 3 + n;
      if (!r.zero) r.res = {neg, 8'(e), 7'((mag / 8) % 128)};
    end
    return r;
  endfunction

  // Called at posedge+#1 with nothing pending; returns at posedge+#1 after the handshake edge.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_, input logic sub);
    int g;
    exp_t e;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a = ta; b = tb_; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
    e = model(ta, tb_, sub);
    e.hs = cyc;
    q.push_back(e);
  endtask

  task automatic waitDone(input int budget);
    int g;
    g = 0;
    while (q.size() != 0 && g < budget) begin
      @(posedge clk); #1; g++;
    end
    if (q.size() != 0) begin
      checkOutput("response_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  function automatic logic [15:0] rndBf16(input int e);
    return {1'($urandom), 8'(e), 7'($urandom)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #2;
    out_ready = stall ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Compare process: every cycle with out_valid high is checked against the queue head.
  initial begin
    exp_t e;
    bit prev_valid, prev_hs;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          checkOutput("valid_drop_after_hs", 32'(out_valid), 32'd0);
          checkOutput("in_ready_after_hs", 32'(in_ready), 32'd1);
        end else if (out_valid) begin
          if (q.size() == 0) begin
            checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = q[0];
            if (!prev_valid) checkOutput("latency", 32'(cyc - e.hs), 32'(e.lat));
            checkOutput("result", 32'(result), 32'(e.res));
            checkOutput("out_zero", 32'(out_zero), 32'(e.zero));
            checkOutput("out_ovf", 32'(out_ovf), 32'(e.ovf));
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
          end
        end
        prev_hs = out_valid && out_ready;
        if (prev_hs && q.size() != 0) void'(q.pop_front());
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    exp_t m;
    int g;

    m = model(16'h3F80, 16'h3F00, 1'b0);
    checkOutput("pin_add_res", 32'(m.res), 32'h3FC0);
    checkOutput("pin_add_lat", 32'(m.lat), 32'd3);
    m = model(16'h3F80, 16'h3F80, 1'b0);
    checkOutput("pin_two_res", 32'(m.res), 32'h4000);
    checkOutput("pin_two_lat", 32'(m.lat), 32'd4);
    m = model(16'h3F80, 16'h3F80, 1'b1);
    checkOutput("pin_cancel_zero", 32'(m.zero), 32'd1);
    m = model(16'h3FC0, 16'h3FA0, 1'b1);
    checkOutput("pin_sub_res", 32'(m.res), 32'h3E80);
    checkOutput("pin_sub_lat", 32'(m.lat), 32'd5);
    m = model(16'h3F80, 16'h3380, 1'b0);
    checkOutput("pin_gap_res", 32'(m.res), 32'h3F80);
    m = model(16'h7F7F, 16'h7F7F, 1'b0);
    checkOutput("pin_ovf_res", 32'(m.res), 32'h7F80);
    checkOutput("pin_ovf_flag", 32'(m.ovf), 32'd1);
    m = model(16'h0080, 16'h00A0, 1'b1);
    checkOutput("pin_flush_zero", 32'(m.zero), 32'd1);
    checkOutput("pin_flush_lat", 32'(m.lat), 32'd4);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(dir_a[i], dir_b[i], dir_s[i]);
      waitDone(50);
    end

    // Backpressure: result held while out_ready is low and in_valid is ignored.
    stall = 1'b1;
    applyStimulus(16'h3F80, 16'h3F00, 1'b0);
    g = 0;
    while (!out_valid && g < 30) begin
      @(posedge clk); #1; g++;
    end
    checkOutput("bp_valid_seen", 32'(out_valid), 32'd1);
    a = 16'h4040; b = 16'h4040; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    waitDone(20);

    // Reset during normalization of 1.5 - 1.25 abandons it silently.
    applyStimulus(16'h3FC0, 16'h3FA0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_out_zero", 32'(out_zero), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("no_stale_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h3F80, 16'h3F00, 1'b0);
    waitDone(50);

    bp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int ea, eb, mode;
      logic [15:0] ra, rb;
      mode = int'($urandom_range(0, 4));
      ea = int'($urandom_range(0, 254));
      case (mode)
        0: eb = int'($urandom_range(0, 254));
        1: begin
          eb = ea + int'($urandom_range(0, 6)) - 3;
          if (eb < 0) eb = 0;
          if (eb > 254) eb = 254;
        end
        2: begin
          ea = int'($urandom_range(0, 4));
          eb = int'($urandom_range(0, 4));
        end
        3: begin
          ea = int'($urandom_range(250, 254));
          eb = ea;
        end
        default: eb = ea;
      endcase
      ra = rndBf16(ea);
      rb = rndBf16(eb);
      if (mode == 4) rb = {1'($urandom), ra[14:4], 4'($urandom)};
      if ($urandom_range(0, 15) == 0) ra = 16'h0000;
      applyStimulus(ra, rb, 1'($urandom));
      waitDone(200);
    end
    bp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
